// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter FSM states, error codes and
// keyboard command bytes used by both the transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_XFER,
    ST_ACK,
    ST_RELEASE,
    ST_ERR
  } ps2_state_e;

  localparam logic [1:0] PS2_ERR_NACK    = 2'b01;
  localparam logic [1:0] PS2_ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a falling-edge
// strobe on the synchronized clock. Pins idle high, so every flop resets to 1.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic clk_m;
  logic data_m;
  logic clk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_m    <= 1'b1;
      clk_s    <= 1'b1;
      clk_prev <= 1'b1;
      data_m   <= 1'b1;
      data_s   <= 1'b1;
    end else begin
      clk_m    <= clk_in;
      clk_s    <= clk_m;
      clk_prev <= clk_s;
      data_m   <= data_in;
      data_s   <= data_m;
    end
  end

  // Built only from registered signals, so the strobe is glitch-free and the
  // consumer's output register gives 3 cycles pin-to-drive latency.
  assign clk_fall = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. Pulls the shared open-collector
// lines low through drive enables and reports ACK, NACK or timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drv,
  output logic       ps2_data_drv,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [13:0] INH_LAST = 14'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] WD_LAST  = 21'(TIMEOUT_CYCLES - 1);

  ps2_state_e  state, state_nxt;
  logic [13:0] inh_cnt, inh_nxt;
  logic [20:0] wd_cnt, wd_nxt;
  logic [3:0]  edge_cnt, edge_nxt;
  logic [8:0]  frame;
  logic        nack;
  logic        accept;
  logic        shift_en;
  logic        clk_s, data_s, clk_fall;

  logic        clk_drv_d, data_drv_d, busy_d, ready_d, done_d, err_d;
  logic [1:0]  err_code_d;

  ps2_line_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .clk_in   (ps2_clk_in),
    .data_in  (ps2_data_in),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .clk_fall (clk_fall)
  );

  assign accept   = tx_valid && tx_ready;
  assign shift_en = clk_fall &&
                    ((state == ST_REQ) || (state == ST_XFER && edge_cnt < 4'd9));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      inh_cnt      <= '0;
      wd_cnt       <= '0;
      edge_cnt     <= '0;
      tx_ready     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'b00;
      ps2_clk_drv  <= 1'b0;
      ps2_data_drv <= 1'b0;
    end else begin
      state        <= state_nxt;
      inh_cnt      <= inh_nxt;
      wd_cnt       <= wd_nxt;
      edge_cnt     <= edge_nxt;
      tx_ready     <= ready_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      err_code     <= err_code_d;
      ps2_clk_drv  <= clk_drv_d;
      ps2_data_drv <= data_drv_d;
    end
  end

  // Frame holds {parity, byte}; bit 0 is the next bit to put on the line.
  always_ff @(posedge clk) begin
    if (accept) frame <= {odd_parity(tx_data), tx_data};
    else if (shift_en) frame <= {1'b0, frame[8:1]};
  end

  always_comb begin
    state_nxt = state;
    inh_nxt   = inh_cnt;
    wd_nxt    = wd_cnt;
    edge_nxt  = edge_cnt;
    nack      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_INHIBIT;
          inh_nxt   = '0;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt >= INH_LAST) begin
          state_nxt = ST_REQ;
          wd_nxt    = '0;
          edge_nxt  = '0;
        end else begin
          inh_nxt = inh_cnt + 14'd1;
        end
      end
      ST_REQ, ST_XFER, ST_ACK, ST_RELEASE: begin
        if (clk_fall) wd_nxt = '0;
        else if (wd_cnt != '1) wd_nxt = wd_cnt + 21'd1;

        if (state == ST_REQ && clk_fall) begin
          state_nxt = ST_XFER;
          edge_nxt  = 4'd1;
        end else if (state == ST_XFER && clk_fall) begin
          edge_nxt = edge_cnt + 4'd1;
          if (edge_cnt == 4'd9) state_nxt = ST_ACK;
        end else if (state == ST_ACK && clk_fall) begin
          edge_nxt = 4'd11;
          if (data_s) begin
            state_nxt = ST_ERR;
            nack      = 1'b1;
          end else begin
            state_nxt = ST_RELEASE;
          end
        end else if (state == ST_RELEASE && done) begin
          state_nxt = ST_IDLE;
        end else if (!clk_fall && wd_cnt >= WD_LAST) begin
          state_nxt = ST_ERR;
        end
      end
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the upcoming state so they line up
  // with the state register.
  always_comb begin
    clk_drv_d  = (state_nxt == ST_INHIBIT);
    data_drv_d = ps2_data_drv;
    case (state_nxt)
      ST_INHIBIT: data_drv_d = (inh_nxt == INH_LAST);
      ST_REQ:     data_drv_d = 1'b1;
      ST_XFER:    if (shift_en) data_drv_d = ~frame[0];
      default:    data_drv_d = 1'b0;
    endcase
    busy_d     = (state_nxt != ST_IDLE);
    ready_d    = (state_nxt == ST_IDLE);
    err_d      = (state_nxt == ST_ERR);
    err_code_d = err_d ? (nack ? PS2_ERR_NACK : PS2_ERR_TIMEOUT) : err_code;
    done_d     = (state == ST_RELEASE) && (state_nxt == ST_RELEASE) &&
                 clk_s && data_s && !done;
  end

endmodule
